ram_dp_clr: RTL



---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_dp_core.sv | 27 ++
 rtl/ram_dp_clr.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with its clear engine.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DATA_W = 8;

    function automatic int unsigned ram_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// Inferred dual-port array: port A read/write (read-first), port B read-only, no reset.
module ram_dp_core
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_wren,
    output logic [DATA_W-1:0] a_q,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_q
);

    logic [DATA_W-1:0] r_mem [ram_depth(ADDR_W)];

    always_ff @(posedge clock) begin
        if (a_wren) begin
            r_mem[a_addr] <= a_data;
        end
        a_q <= r_mem[a_addr];
        b_q <= r_mem[b_addr];
    end

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM with clear engine, busy flag and A-write/B-read bypass.
// Define RAM_DP_CLR_OUTREG_EN to add a second output register on both ports.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int unsigned         ADDR_W         = DEF_ADDR_W,
    parameter int unsigned         DATA_W         = DEF_DATA_W,
    parameter logic [DATA_W-1:0]   CLEAR_VAL      = '0,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_wren,
    output logic [DATA_W-1:0] a_q,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_q
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_rd_ok;
    logic                r_coll;
    logic [DATA_W-1:0]   r_coll_data;

    logic                w_clearing;
    logic                w_idle;
    logic                w_we;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_core_a_q;
    logic [DATA_W-1:0]   w_core_b_q;
    logic [DATA_W-1:0]   w_a_q;
    logic [DATA_W-1:0]   w_b_q;

    assign w_clearing = (r_state == ST_CLEAR) && reset_n;
    assign w_idle     = (r_state == ST_IDLE) && reset_n;
    assign w_we       = w_clearing || (w_idle && a_wren);
    assign w_wr_addr  = w_clearing ? r_ptr : a_addr;
    assign w_wr_data  = w_clearing ? CLEAR_VAL : a_data;

    ram_dp_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clock  (clock),
        .a_addr (w_wr_addr),
        .a_data (w_wr_data),
        .a_wren (w_we),
        .a_q    (w_core_a_q),
        .b_addr (b_addr),
        .b_q    (w_core_b_q)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_IDLE;
            end
            r_ptr       <= '0;
            r_rd_ok     <= 1'b0;
            r_coll      <= 1'b0;
            r_coll_data <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (&r_ptr) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A read only returns data if the array stays with port A on the next cycle
            r_rd_ok     <= w_idle && !clr_req;
            r_coll      <= w_idle && a_wren && (a_addr == b_addr);
            r_coll_data <= a_data;
        end
    end

    assign busy  = (r_state == ST_CLEAR);
    assign w_a_q = r_rd_ok ? w_core_a_q : '0;
    assign w_b_q = r_rd_ok ? (r_coll ? r_coll_data : w_core_b_q) : '0;

`ifdef RAM_DP_CLR_OUTREG_EN
    logic              w_busy_nxt;
    logic [DATA_W-1:0] r_a_q2;
    logic [DATA_W-1:0] r_b_q2;

    assign w_busy_nxt = (w_idle && clr_req) || (w_clearing && !(&r_ptr));

    always_ff @(posedge clock) begin
        if (!reset_n || w_busy_nxt) begin
            r_a_q2 <= '0;
            r_b_q2 <= '0;
        end else begin
            r_a_q2 <= w_a_q;
            r_b_q2 <= w_b_q;
        end
    end

    assign a_q = r_a_q2;
    assign b_q = r_b_q2;
`else
    assign a_q = w_a_q;
    assign b_q = w_b_q;
`endif

endmodule
